// File: rtl/lpc_frame_ctrl.sv
// LPC frame controller: counts input samples into frames, kicks the LDR solver,
// and buffers solved coefficient sets in a 2-entry ping-pong buffer behind an Avalon-MM slave.
module lpc_frame_ctrl #(
  parameter int FRAME_LEN_DEF = 240,
  parameter int TIMEOUT       = 1023
) (
  input  logic         avalon_clk,
  input  logic         rst,
  input  logic         sample_v,
  output logic         frame_start,
  input  logic         ldr_done,
  input  logic [175:0] coef_in,
  input  logic         voiced_in,
  input  logic [15:0]  freq_in,
  input  logic [3:0]   address,
  input  logic         read,
  input  logic         write,
  input  logic [15:0]  writedata,
  output logic [15:0]  readdata,
  output logic         irq
);

  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SOLVE = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               enable_r, irq_en_r;
  logic [15:0]        frame_len_r, frame_len_lat_r;
  logic [15:0]        cnt_r, cnt_nxt_s;
  logic [TMO_W-1:0]   tmo_cnt_r, tmo_nxt_s;
  logic [1:0]         frames_avail_r;
  logic               head_r, tail_r;
  logic               overflow_r, timeout_r;
  logic               frame_start_r, irq_r;
  logic [15:0]        readdata_r, rdata_s;

  logic [15:0]        coef_mem_r [2][11];
  logic               voiced_mem_r [2];
  logic [15:0]        freq_mem_r [2];

  logic               cnt_end_s, frame_hit_s, tmo_hit_s;
  logic               latch_len_s, frame_start_nxt_s, timeout_set_s, store_s;
  logic               wr_ctrl_s, wr_len_s, wr_cmd_s, pop_s, store_ok_s, overflow_set_s;
  logic [3:0]         coef_idx_s;

  assign cnt_end_s      = ({1'b0, cnt_r} + 17'd1) >= {1'b0, frame_len_lat_r};
  assign frame_hit_s    = sample_v && cnt_end_s;
  assign tmo_hit_s      = (tmo_cnt_r == TMO_LAST);
  assign wr_ctrl_s      = write && (address == 4'h0);
  assign wr_len_s       = write && (address == 4'h1);
  assign wr_cmd_s       = write && (address == 4'h3);
  assign pop_s          = wr_cmd_s && writedata[0] && (frames_avail_r != 2'd0);
  // A full buffer still accepts a frame when a pop frees the head bank in the same cycle.
  assign store_ok_s     = store_s && !rst && ((frames_avail_r != 2'd2) || pop_s);
  assign overflow_set_s = store_s && (frames_avail_r == 2'd2) && !pop_s;
  assign coef_idx_s     = address - 4'd4;

  // FSM state register
  always_ff @(posedge avalon_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; clearing enable wins in every state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_r) state_nxt_s = ST_COUNT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_COUNT: begin
        if (!enable_r)        state_nxt_s = ST_IDLE;
        else if (frame_hit_s) state_nxt_s = ST_SOLVE;
        else                  state_nxt_s = ST_COUNT;
      end
      ST_SOLVE: begin
        if (!enable_r)      state_nxt_s = ST_IDLE;
        else if (ldr_done)  state_nxt_s = ST_STORE;
        else if (tmo_hit_s) state_nxt_s = ST_COUNT;
        else                state_nxt_s = ST_SOLVE;
      end
      ST_STORE: begin
        if (!enable_r) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_COUNT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: counter updates and per-state strobes
  always_comb begin
    cnt_nxt_s         = cnt_r;
    tmo_nxt_s         = {TMO_W{1'b0}};
    latch_len_s       = 1'b0;
    frame_start_nxt_s = 1'b0;
    timeout_set_s     = 1'b0;
    store_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s   = 16'd0;
        latch_len_s = enable_r;
      end
      ST_COUNT: begin
        if (!enable_r) begin
          cnt_nxt_s = 16'd0;
        end else if (frame_hit_s) begin
          cnt_nxt_s         = 16'd0;
          latch_len_s       = 1'b1;
          frame_start_nxt_s = 1'b1;
        end else if (sample_v) begin
          cnt_nxt_s = cnt_r + 16'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_SOLVE: begin
        tmo_nxt_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        if (!enable_r) begin
          cnt_nxt_s = 16'd0;
        end else begin
          cnt_nxt_s     = sample_v ? (cnt_r + 16'd1) : cnt_r;
          timeout_set_s = !ldr_done && tmo_hit_s;
        end
      end
      ST_STORE: begin
        store_s = 1'b1;
        if (!enable_r) cnt_nxt_s = 16'd0;
        else           cnt_nxt_s = sample_v ? (cnt_r + 16'd1) : cnt_r;
      end
      default: cnt_nxt_s = 16'd0;
    endcase
  end

  // Register read mux; frame words read as zero while the buffer is empty
  always_comb begin
    rdata_s = 16'h0000;
    case (address)
      4'h0: rdata_s = {14'h0000, irq_en_r, enable_r};
      4'h1: rdata_s = frame_len_r;
      4'h2: rdata_s = {10'h000, state_r, timeout_r, overflow_r, frames_avail_r};
      4'h3: rdata_s = 16'h0000;
      4'hF: begin
        if (frames_avail_r != 2'd0) rdata_s = {voiced_mem_r[head_r], freq_mem_r[head_r][14:0]};
        else                        rdata_s = 16'h0000;
      end
      default: begin
        if (frames_avail_r != 2'd0) rdata_s = coef_mem_r[head_r][coef_idx_s];
        else                        rdata_s = 16'h0000;
      end
    endcase
  end

  // Control/status registers, counters, buffer pointers and registered outputs
  always_ff @(posedge avalon_clk) begin
    if (rst) begin
      enable_r        <= 1'b0;
      irq_en_r        <= 1'b0;
      frame_len_r     <= 16'(FRAME_LEN_DEF);
      frame_len_lat_r <= 16'(FRAME_LEN_DEF);
      cnt_r           <= 16'd0;
      tmo_cnt_r       <= {TMO_W{1'b0}};
      frames_avail_r  <= 2'd0;
      head_r          <= 1'b0;
      tail_r          <= 1'b0;
      overflow_r      <= 1'b0;
      timeout_r       <= 1'b0;
      frame_start_r   <= 1'b0;
      readdata_r      <= 16'h0000;
      irq_r           <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        enable_r <= writedata[0];
        irq_en_r <= writedata[1];
      end
      if (wr_len_s) frame_len_r <= (writedata < 16'd16) ? 16'd16 : writedata;
      if (latch_len_s) frame_len_lat_r <= frame_len_r;
      cnt_r         <= cnt_nxt_s;
      tmo_cnt_r     <= tmo_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      if (timeout_set_s)                      timeout_r <= 1'b1;
      else if (wr_cmd_s && writedata[2])      timeout_r <= 1'b0;
      if (overflow_set_s)                     overflow_r <= 1'b1;
      else if (wr_cmd_s && writedata[1])      overflow_r <= 1'b0;
      if (store_ok_s) tail_r <= ~tail_r;
      if (pop_s)      head_r <= ~head_r;
      case ({store_ok_s, pop_s})
        2'b10:   frames_avail_r <= frames_avail_r + 2'd1;
        2'b01:   frames_avail_r <= frames_avail_r - 2'd1;
        default: frames_avail_r <= frames_avail_r;
      endcase
      readdata_r <= read ? rdata_s : 16'h0000;
      irq_r      <= irq_en_r && ((frames_avail_r != 2'd0) || overflow_r || timeout_r);
    end
  end

  // Frame buffer storage; contents are qualified by frames_avail so no reset is needed
  always_ff @(posedge avalon_clk) begin
    if (store_ok_s) begin
      for (int i = 0; i < 11; i++) begin
        coef_mem_r[tail_r][i] <= coef_in[16*i +: 16];
      end
      voiced_mem_r[tail_r] <= voiced_in;
      freq_mem_r[tail_r]   <= freq_in;
    end
  end

  assign frame_start = frame_start_r;
  assign readdata    = readdata_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Scoreboard bench for lpc_frame_ctrl: reads push expected data, a monitor pops and compares.
module tb_lpc_frame_ctrl;

  logic         avalon_clk = 1'b0;
  logic         rst, sample_v, ldr_done, voiced_in, read, write;
  logic [175:0] coef_in;
  logic [15:0]  freq_in, writedata;
  logic [3:0]   address;
  logic         frame_start, irq;
  logic [15:0]  readdata;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_count = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];

  lpc_frame_ctrl dut (
    .avalon_clk (avalon_clk),
    .rst        (rst),
    .sample_v   (sample_v),
    .frame_start(frame_start),
    .ldr_done   (ldr_done),
    .coef_in    (coef_in),
    .voiced_in  (voiced_in),
    .freq_in    (freq_in),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 avalon_clk = ~avalon_clk;

  always @(posedge avalon_clk) begin
    if (frame_start === 1'b1) fs_count = fs_count + 1;
  end

  // Monitor: a read sampled at this edge must produce the queued value; otherwise readdata is 0
  initial begin
    logic        rd_s;
    logic [15:0] e;
    string       nm;
    forever begin
      @(posedge avalon_clk);
      rd_s = read;
      #1;
      if (rd_s === 1'b1) begin
        n_tests = n_tests + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_read: readdata=0x%0h with no expected entry", readdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (readdata !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: readdata=0x%0h expected 0x%0h", nm, readdata, e);
          end
        end
      end else begin
        n_tests = n_tests + 1;
        if (readdata !== 16'h0000) begin
          n_fail = n_fail + 1;
          $display("FAIL idle_readdata: readdata=0x%0h expected 0x0", readdata);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge avalon_clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    write = 1'b1; address = a; writedata = d;
    tick();
    write = 1'b0; writedata = 16'h0000;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    read = 1'b1; address = a;
    tick();
    read = 1'b0;
  endtask

  // n one-cycle sample pulses with a gap; returns in the cycle right after the last pulse edge
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sample_v = 1'b1;
      tick();
      sample_v = 1'b0;
      if (i != n - 1) tick();
    end
  endtask

  task automatic load(input int base, input logic v, input logic [15:0] f);
    for (int i = 0; i < 11; i++) coef_in[16*i +: 16] = 16'(base + i);
    voiced_in = v;
    freq_in   = f;
  endtask

  // ldr_done for one cycle, optionally pop during the STORE cycle, then let irq settle
  task automatic ldr(input logic pop);
    ldr_done = 1'b1;
    tick();
    ldr_done = 1'b0;
    if (pop) wr(4'h3, 16'h0001);
    else     tick();
    tick();
  endtask

  task automatic do_frame(input int base, input logic v, input logic [15:0] f, input logic pop);
    int fs0;
    fs0 = fs_count;
    pulses(16);
    check("frame_start_pulse", {15'h0, frame_start}, 16'h1);
    load(base, v, f);
    ldr(pop);
    check("frame_start_count", 16'(fs_count - fs0), 16'd1);
  endtask

  initial begin
    int fs0;
    rst = 1'b1; sample_v = 1'b0; ldr_done = 1'b0; voiced_in = 1'b0; read = 1'b0; write = 1'b0;
    coef_in = 176'h0; freq_in = 16'h0; writedata = 16'h0; address = 4'h0;
    repeat (3) tick();
    check("rst_frame_start", {15'h0, frame_start}, 16'h0);
    check("rst_irq", {15'h0, irq}, 16'h0);
    rst = 1'b0;
    rd(4'h0, 16'h0000, "ctrl_rst");
    rd(4'h1, 16'd240, "frame_len_rst");
    rd(4'h2, 16'h0000, "status_rst");
    rd(4'h3, 16'h0000, "cmd_reads_zero");
    rd(4'h4, 16'h0000, "coef_empty");
    wr(4'h3, 16'h0001);
    rd(4'h2, 16'h0000, "pop_empty_ignored");
    wr(4'h1, 16'd5);
    rd(4'h1, 16'd16, "frame_len_min");

    // First frame of 16 samples
    wr(4'h0, 16'h0003);
    tick();
    fs0 = fs_count;
    pulses(15);
    check("no_early_start", {15'h0, frame_start}, 16'h0);
    pulses(1);
    check("start_after_16", {15'h0, frame_start}, 16'h1);
    tick();
    check("start_one_cycle", {15'h0, frame_start}, 16'h0);
    check("single_start", 16'(fs_count - fs0), 16'd1);
    rd(4'h2, 16'h0020, "status_solve");
    load(1, 1'b1, 16'd80);
    ldr(1'b0);
    rd(4'h2, 16'h0011, "status_avail1");
    for (int i = 0; i < 11; i++) rd(4'(4 + i), 16'(1 + i), "coef_word");
    rd(4'hF, 16'h8050, "voiced_freq");
    check("irq_avail", {15'h0, irq}, 16'h1);

    // Fill and overflow
    do_frame(101, 1'b0, 16'h1234, 1'b0);
    rd(4'h2, 16'h0012, "status_avail2");
    do_frame(201, 1'b1, 16'h0555, 1'b0);
    rd(4'h2, 16'h0016, "status_overflow");
    rd(4'h4, 16'd1, "head_a0_intact");
    rd(4'hE, 16'd11, "head_a10_intact");
    rd(4'hF, 16'h8050, "head_vf_intact");
    wr(4'h3, 16'h0001);
    rd(4'h2, 16'h0015, "status_after_pop");
    rd(4'h4, 16'd101, "second_a0");
    rd(4'hE, 16'd111, "second_a10");
    rd(4'hF, 16'h1234, "second_vf");
    do_frame(301, 1'b0, 16'h0001, 1'b0);
    rd(4'h2, 16'h0016, "refill_overflow_sticky");
    wr(4'h3, 16'h0002);
    rd(4'h2, 16'h0012, "overflow_cleared");
    do_frame(401, 1'b1, 16'h7FFF, 1'b1);
    rd(4'h2, 16'h0012, "pop_store_same_cycle");
    rd(4'h4, 16'd301, "head_after_popstore");
    wr(4'h3, 16'h0001);
    rd(4'h4, 16'd401, "newest_a0");
    rd(4'hF, 16'hFFFF, "newest_vf");
    rd(4'h2, 16'h0011, "status_avail1_again");

    // Solve timeout
    pulses(16);
    check("start_before_timeout", {15'h0, frame_start}, 16'h1);
    repeat (1022) tick();
    rd(4'h2, 16'h0021, "still_solve");
    rd(4'h2, 16'h0019, "timeout_set");
    wr(4'h3, 16'h0004);
    rd(4'h2, 16'h0011, "timeout_cleared");
    ldr_done = 1'b1; tick(); ldr_done = 1'b0; tick();
    rd(4'h2, 16'h0011, "late_ldr_ignored");

    // Mid-frame FRAME_LEN change takes effect at the next frame
    fs0 = fs_count;
    pulses(8);
    wr(4'h1, 16'd32);
    pulses(8);
    check("boundary_old_len", {15'h0, frame_start}, 16'h1);
    rd(4'h1, 16'd32, "frame_len_rb");
    load(501, 1'b0, 16'h0002);
    ldr(1'b0);
    pulses(31);
    check("no_start_at_31", {15'h0, frame_start}, 16'h0);
    check("starts_before_32", 16'(fs_count - fs0), 16'd1);
    pulses(1);
    check("start_at_32", {15'h0, frame_start}, 16'h1);

    // Disable during SOLVE after counting a few samples, then late ldr_done
    pulses(5);
    wr(4'h0, 16'h0002);
    tick();
    load(601, 1'b1, 16'h0003);
    ldr_done = 1'b1; tick(); ldr_done = 1'b0;
    tick(); tick();
    rd(4'h2, 16'h0002, "disabled_no_store");
    rd(4'h4, 16'd401, "head_unchanged");
    check("irq_disabled_avail", {15'h0, irq}, 16'h1);
    wr(4'h0, 16'h0003);
    tick();
    pulses(31);
    check("counter_restart", {15'h0, frame_start}, 16'h0);
    pulses(1);
    check("restart_start_at_32", {15'h0, frame_start}, 16'h1);

    // Reset mid-operation wins over a concurrent ldr_done
    ldr_done = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; ldr_done = 1'b0;
    check("rst_mid_irq", {15'h0, irq}, 16'h0);
    rd(4'h2, 16'h0000, "status_after_rst");
    rd(4'h0, 16'h0000, "ctrl_after_rst");
    rd(4'h1, 16'd240, "len_after_rst");
    rd(4'h4, 16'h0000, "coef_after_rst");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
